// File: rtl/x_mem_pkg.sv
// ============================================================================
// Module      : x_mem_pkg
// Description : Shared constants and state encoding for the X solution-vector
//               memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package x_mem_pkg;

  // Vector length, element width and the address width that covers it
  localparam int X_MEM_HEIGHT  = 64;
  localparam int ELEMENT_WIDTH = 32;
  localparam int ADDR_WIDTH    = $clog2(X_MEM_HEIGHT);

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD      = 2'd1,
    RD_LAST = 2'd2,
    WR      = 2'd3
  } x_arb_state_t;

endpackage

`default_nettype wire

// File: rtl/x_arb_rr_pick.sv
// ============================================================================
// Module      : x_arb_rr_pick
// Description : Two-way picker between the read and write clients of the
//               X memory. Round-robin on conflict by default; when the
//               X_ARB_WR_PRIORITY_EN macro is defined the writer always wins
//               a conflict.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module x_arb_rr_pick (
  input  logic rd_req,
  input  logic wr_req,
  input  logic last_grant,   // 1 = the write client was granted last
  output logic pick_rd,
  output logic pick_wr
);

`ifdef X_ARB_WR_PRIORITY_EN
  // Fixed write priority: history is irrelevant, the reader may starve
  logic w_unused_last_grant;
  assign w_unused_last_grant = last_grant;
  assign pick_wr = wr_req;
  assign pick_rd = rd_req & ~wr_req;
`else
  // On conflict the client that was not granted last wins
  assign pick_rd = rd_req & (~wr_req | last_grant);
  assign pick_wr = wr_req & (~rd_req | ~last_grant);
`endif

endmodule

`default_nettype wire

// File: rtl/x_mem_arbiter.sv
// ============================================================================
// Module      : x_mem_arbiter
// Description : Shares the single X memory port between the PE-array read
//               client and the update-unit write client. Each grant is a
//               full-vector element-serial burst over addresses
//               0..X_MEM_HEIGHT-1. Optional macro X_ARB_WR_PRIORITY_EN
//               (in x_arb_rr_pick) gives the writer fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module x_mem_arbiter
  import x_mem_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  // read client
  input  logic                     rd_req,
  output logic                     rd_gnt,
  output logic                     rd_valid,
  output logic [ELEMENT_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0]    rd_idx,
  output logic                     rd_done,
  // write client
  input  logic                     wr_req,
  output logic                     wr_gnt,
  input  logic                     wr_valid,
  input  logic [ELEMENT_WIDTH-1:0] wr_data,
  output logic                     wr_ready,
  output logic                     wr_done,
  // memory port
  output logic                     mem_re,
  output logic                     mem_we,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic [ELEMENT_WIDTH-1:0] mem_wdata,
  input  logic [ELEMENT_WIDTH-1:0] mem_rdata
);

  localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(X_MEM_HEIGHT - 1);
  localparam logic [ADDR_WIDTH-1:0] c_one       = ADDR_WIDTH'(1);

  x_arb_state_t          r_state;
  x_arb_state_t          w_next_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_last_grant;   // 1 = write was granted last
  logic                  r_rd_valid;
  logic [ADDR_WIDTH-1:0] r_rd_idx;
  logic                  w_pick_rd;
  logic                  w_pick_wr;
  logic                  w_cnt_last;

  assign w_cnt_last = (r_cnt == c_last_addr);

  x_arb_rr_pick u_pick (
    .rd_req     (rd_req),
    .wr_req     (wr_req),
    .last_grant (r_last_grant),
    .pick_rd    (w_pick_rd),
    .pick_wr    (w_pick_wr)
  );

  // State register; reset aborts any burst in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Next state and all memory/client strobes, decoded from the current state
  always_comb begin
    w_next_state = r_state;
    rd_gnt       = 1'b0;
    rd_done      = 1'b0;
    wr_gnt       = 1'b0;
    wr_ready     = 1'b0;
    wr_done      = 1'b0;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    case (r_state)
      IDLE: begin
        if (w_pick_rd)      w_next_state = RD;
        else if (w_pick_wr) w_next_state = WR;
      end
      RD: begin
        rd_gnt   = 1'b1;
        mem_re   = 1'b1;
        mem_addr = r_cnt;
        if (w_cnt_last) w_next_state = RD_LAST;
      end
      RD_LAST: begin
        // no new address; the last datum returns this cycle
        rd_gnt       = 1'b1;
        rd_done      = 1'b1;
        w_next_state = IDLE;
      end
      WR: begin
        wr_gnt    = 1'b1;
        wr_ready  = 1'b1;
        mem_we    = wr_valid;
        mem_addr  = r_cnt;
        // write data passes through only while the writer owns the port
        mem_wdata = wr_data;
        if (wr_valid && w_cnt_last) begin
          wr_done      = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Element counter: advances per issued read / accepted write, cleared otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        RD:      r_cnt <= w_cnt_last ? '0 : r_cnt + c_one;
        WR:      if (wr_valid) r_cnt <= w_cnt_last ? '0 : r_cnt + c_one;
        default: r_cnt <= '0;
      endcase
    end
  end

  // Grant history for round-robin; starts as write so a read wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
    end else if (r_state == IDLE) begin
      if (w_pick_rd)      r_last_grant <= 1'b0;
      else if (w_pick_wr) r_last_grant <= 1'b1;
    end
  end

  // Read-return pipeline: tracks the one-cycle memory read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_idx   <= '0;
    end else begin
      r_rd_valid <= mem_re;
      r_rd_idx   <= mem_re ? mem_addr : '0;
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_idx   = r_rd_idx;
  assign rd_data  = r_rd_valid ? mem_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_x_mem_arbiter.sv
// ============================================================================
// Module      : tb_x_mem_arbiter
// Description : Directed self-checking bench for x_mem_arbiter with a
//               behavioural 64 x 32 memory (1-cycle read latency).
//               Honors X_ARB_WR_PRIORITY_EN for the conflict expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_x_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_req, rd_gnt, rd_valid, rd_done;
  logic [31:0] rd_data;
  logic [5:0]  rd_idx;
  logic        wr_req, wr_gnt, wr_valid, wr_ready, wr_done;
  logic [31:0] wr_data;
  logic        mem_re, mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:63];
  logic        preload;

  int n_assert = 0;
  int n_fail   = 0;

  x_mem_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_req    (rd_req),
    .rd_gnt    (rd_gnt),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_idx    (rd_idx),
    .rd_done   (rd_done),
    .wr_req    (wr_req),
    .wr_gnt    (wr_gnt),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .wr_done   (wr_done),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural X memory
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'(i * 3);
      mem_rdata <= 32'h0;
    end else begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rd_gnt"},   32'(rd_gnt),   32'h0);
    chk({tag, "_wr_gnt"},   32'(wr_gnt),   32'h0);
    chk({tag, "_wr_ready"}, 32'(wr_ready), 32'h0);
    chk({tag, "_strobes"},  {28'h0, mem_re, mem_we, rd_done, wr_done}, 32'h0);
    chk({tag, "_addr"},     32'(mem_addr), 32'h0);
    chk({tag, "_wdata"},    mem_wdata,     32'h0);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'h0);
  endtask

  // Expected memory image for each readback
  function automatic logic [31:0] exp_val(input int kind, input int k);
    case (kind)
      0:       return 32'(k * 3);
      1:       return 32'h1000 + 32'(k);
      default: return (k < 20) ? 32'h3000 + 32'(k) : 32'h2000 + 32'(k);
    endcase
  endfunction

  // Full read burst from IDLE; rd_req is low from cycle 'hold' onwards
  task automatic check_read(input int kind, input int hold);
    rd_req = 1'b1;
    tick();  // cycle 1
    chk("rd_c1_gnt",  32'(rd_gnt),   32'h1);
    chk("rd_c1_re",   32'(mem_re),   32'h1);
    chk("rd_c1_addr", 32'(mem_addr), 32'h0);
    chk("rd_c1_nvld", 32'(rd_valid), 32'h0);
    if (hold <= 1) rd_req = 1'b0;
    for (int c = 2; c <= 65; c++) begin
      tick();
      if (c >= hold) rd_req = 1'b0;
      chk("rd_valid", 32'(rd_valid), 32'h1);
      chk("rd_idx",   32'(rd_idx),   32'(c - 2));
      chk("rd_data",  rd_data,       exp_val(kind, c - 2));
      chk("rd_done",  32'(rd_done),  32'(c == 65));
      chk("rd_re",    32'(mem_re),   32'(c <= 64));
      if (c <= 64) chk("rd_addr", 32'(mem_addr), 32'(c - 1));
    end
    tick();  // cycle 66: back in IDLE
    chk("rd_c66_gnt",  32'(rd_gnt),   32'h0);
    chk("rd_c66_nvld", 32'(rd_valid), 32'h0);
  endtask

  // Full write burst from IDLE; optional 3-cycle stalls at elements 5 and 40
  task automatic write_burst(input logic [31:0] base, input bit stalls);
    int k = 0;
    int s5 = 0;
    int s40 = 0;
    int last_c;
    bit stall;
    last_c = stalls ? 70 : 64;
    wr_req = 1'b1;
    tick();  // cycle 1
    wr_req = 1'b0;
    for (int c = 1; c <= last_c; c++) begin
      stall = stalls && ((k == 5 && s5 < 3) || (k == 40 && s40 < 3));
      wr_valid = !stall;
      wr_data  = base + 32'(k);
      #1;
      chk("wr_gnt",   32'(wr_gnt),   32'h1);
      chk("wr_ready", 32'(wr_ready), 32'h1);
      chk("wr_re",    32'(mem_re),   32'h0);
      chk("wr_done",  32'(wr_done),  32'(c == last_c));
      if (stall) begin
        chk("wr_stall_we", 32'(mem_we), 32'h0);
        if (k == 5) s5++;
        else s40++;
      end else begin
        chk("wr_we",    32'(mem_we),   32'h1);
        chk("wr_addr",  32'(mem_addr), 32'(k));
        chk("wr_wdata", mem_wdata,     base + 32'(k));
        k++;
      end
      tick();
    end
    wr_valid = 1'b0;
    #1;
    chk("wr_end_gnt", 32'(wr_gnt), 32'h0);
    chk("wr_end_cnt", 32'(k),      32'd64);
  endtask

  // Guard against a hung run
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    rst_n    = 1'b0;
    rd_req   = 1'b0;
    wr_req   = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 32'h0;
    preload  = 1'b1;
    #1;
    chk_quiet("reset");
    tick();
    preload = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk_quiet("idle");

    // Lone read of the preloaded image, rd_req pulsed
    check_read(0, 1);

    // Lone write without stalls, then read it back dropping rd_req at cycle 10
    write_burst(32'h1000, 1'b0);
    check_read(1, 10);

    // Write with two 3-cycle stalls
    write_burst(32'h2000, 1'b1);

    // Reset while element 20 of a write is on the bus
    wr_req = 1'b1;
    tick();
    wr_req = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      wr_valid = 1'b1;
      wr_data  = 32'h3000 + 32'(c - 1);
      tick();
    end
    wr_valid = 1'b1;
    wr_data  = 32'h3000 + 32'd20;
    #1;
    chk("rst_pre_we",   32'(mem_we),   32'h1);
    chk("rst_pre_addr", 32'(mem_addr), 32'd20);
    rst_n = 1'b0;
    #1;
    chk_quiet("rst_async");
    wr_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_read(2, 1);

    // Both clients requesting continuously from reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    rd_req   = 1'b1;
    wr_req   = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 32'h4000;
    bad = 0;
    tick();  // cycle 1
    for (int c = 1; c <= 132; c++) begin
      if (rd_gnt && wr_gnt) bad++;
      if (mem_re && mem_we) bad++;
`ifdef X_ARB_WR_PRIORITY_EN
      if (c == 1 || c == 66 || c == 131) begin
        chk("arb_wr_gnt", 32'(wr_gnt), 32'h1);
        chk("arb_rd_gnt", 32'(rd_gnt), 32'h0);
      end
      if (c == 65 || c == 130) chk("arb_idle", {30'h0, rd_gnt, wr_gnt}, 32'h0);
`else
      if (c == 1 || c == 132) begin
        chk("arb_rd_gnt", 32'(rd_gnt), 32'h1);
        chk("arb_wr_gnt", 32'(wr_gnt), 32'h0);
      end
      if (c == 67) begin
        chk("arb_wr_gnt2", 32'(wr_gnt), 32'h1);
        chk("arb_rd_gnt2", 32'(rd_gnt), 32'h0);
      end
      if (c == 66 || c == 131) chk("arb_idle", {30'h0, rd_gnt, wr_gnt}, 32'h0);
`endif
      if (c < 132) tick();
    end
    chk("arb_mutex", 32'(bad), 32'h0);
    rd_req   = 1'b0;
    wr_req   = 1'b0;
    wr_valid = 1'b0;
    rst_n    = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
